decryption: RTL and testbench

DECRYPTION -- requirements
Module: decryption

---
 rtl/crypt_pkg.sv | 76 +++++++
 rtl/decrypt_stage.sv | 33 +++
 rtl/decryption.sv | 101 ++++++++++
 tb/tb_decryption.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/crypt_pkg.sv
// crypt_pkg: rotate constant, pipeline stage bundle and bit helpers
// shared by the encryption and decryption pipelines (widths up to MAX_N).
package crypt_pkg;

  localparam int ROT    = 5;
  localparam int STAGES = 5;
  localparam int MAX_N  = 64;
  localparam int IDX_W  = $clog2(MAX_N);

  typedef logic [MAX_N-1:0] word_t;

  typedef struct packed {
    logic  valid;
    word_t word;
    word_t key;
  } stage_t;

  // Rotate the low n bits of x right by amt; bits at or above n read 0.
  function automatic word_t rot_r(
    input word_t x,
    input int    n,
    input int    amt
  );
    word_t            r;
    logic [IDX_W-1:0] src;
    r   = '0;
    src = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        src  = IDX_W'((i + amt) % n);
        r[i] = x[src];
      end
    end
    return r;
  endfunction

  // Mirror the low n bits of x; bits at or above n read 0.
  function automatic word_t rev(
    input word_t x,
    input int    n
  );
    word_t            r;
    logic [IDX_W-1:0] src;
    r   = '0;
    src = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        src  = IDX_W'(n - 1 - i);
        r[i] = x[src];
      end
    end
    return r;
  endfunction

  // R2(x) = {x[4:0], x[n-1:5]}
  function automatic word_t r2(
    input word_t x,
    input int    n
  );
    return rot_r(x, n, ROT);
  endfunction

  // R5(x) = {x[n-6:0], x[n-1:n-5]}, the inverse of R2
  function automatic word_t r5(
    input word_t x,
    input int    n
  );
    return rot_r(x, n, n - ROT);
  endfunction

  // Ones in the low n bits.
  function automatic word_t lo_mask(input int n);
    return {MAX_N{1'b1}} >> (MAX_N - n);
  endfunction

endpackage

// File: rtl/decrypt_stage.sv
// decrypt_stage: one pipeline register (valid/word/key) with load enable.
// Ports: clock, reset (async, high), en, d (next bundle), q (held bundle).
module decrypt_stage
  import crypt_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   en,
  input  stage_t d,
  output stage_t q
);

  stage_t stage_d;
  stage_t stage_q;

  always_comb begin
    stage_d = stage_q;
    if (en) begin
      stage_d = d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q;

endmodule

// File: rtl/decryption.sv
// decryption: 5-stage valid/ready pipeline undoing the team encryption.
// Ports: clock, reset (async, high), key/e_data/in_valid/in_ready in,
// data/out_valid/out_ready out. Parameter N: word width, 6..MAX_N.
// Macro DECRYPTION_WORD_COUNT_EN adds the 16-bit word_count output.
module decryption
  import crypt_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] key,
  input  logic [N-1:0] e_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] data,
  output logic         out_valid,
  input  logic         out_ready
`ifdef DECRYPTION_WORD_COUNT_EN
  ,
  output logic [15:0]  word_count
`endif
);

  localparam word_t MASK = lo_mask(N);

  stage_t s_d [STAGES];
  stage_t s_q [STAGES];
  logic   advance;

  // The whole pipe moves as one; it only stalls when the last
  // stage holds a word the consumer has not taken.
  assign advance  = !s_q[STAGES-1].valid || out_ready;
  assign in_ready = advance;

  // Words are zero-extended into the shared MAX_N-wide bundle, and
  // every transform keeps bits at or above N at zero.
  always_comb begin
    s_d[0] = '0;
    if (in_valid) begin
      s_d[0].valid = 1'b1;
      s_d[0].word  = r2(word_t'(e_data), N);
      s_d[0].key   = word_t'(key);
    end

    s_d[1]      = s_q[0];
    s_d[1].word = rev(s_q[0].word, N);

    s_d[2]      = s_q[1];
    s_d[2].word = ~s_q[1].word & MASK;

    s_d[3]      = s_q[2];
    s_d[3].word = r5(s_q[2].word, N);

    s_d[4]      = s_q[3];
    s_d[4].word = s_q[3].word ^ s_q[3].key;
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    decrypt_stage u_stage (
      .clock (clock),
      .reset (reset),
      .en    (advance),
      .d     (s_d[i]),
      .q     (s_q[i])
    );
  end

  assign data      = s_q[STAGES-1].word[N-1:0];
  assign out_valid = s_q[STAGES-1].valid;

  // The last key and the zero padding have no reader.
  logic unused_s5;
  assign unused_s5 = ^{s_q[STAGES-1].word, s_q[STAGES-1].key};

`ifdef DECRYPTION_WORD_COUNT_EN
  logic [15:0] cnt_d;
  logic [15:0] cnt_q;

  // Wraps naturally from 16'hFFFF to 16'h0000.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign word_count = cnt_q;
`else
  // No delivered-word counter in this build.
`endif

endmodule

// File: tb/tb_decryption.sv
// tb_decryption: directed and random checks of decryption (N=8)
// against an arithmetic reference of the cipher.
module tb_decryption;

  localparam int N = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] key;
  logic [N-1:0] e_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] data;
  logic         out_valid;
  logic         out_ready;
`ifdef DECRYPTION_WORD_COUNT_EN
  logic [15:0]  word_count;
`endif

  decryption #(.N(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .key        (key),
    .e_data     (e_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data       (data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef DECRYPTION_WORD_COUNT_EN
    ,
    .word_count (word_count)
`endif
  );

  always #5 clock = ~clock;

  int           checks   = 0;
  int           errors   = 0;
  int           accepted = 0;
  bit           sb_en    = 1'b0;
  bit           stall_prev = 1'b0;
  logic [N-1:0] data_prev = '0;
  logic [N-1:0] cur_d = '0;
  logic [N-1:0] exp_q [$];

  function automatic logic [7:0] rotl(input logic [7:0] x, input int s);
    int v;
    v = int'(x);
    return 8'(((v << s) | (v >> (8 - s))) & 255);
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7 - i];
    return r;
  endfunction

  // R2 is a left rotate by 3 and R5 a left rotate by 5 at N=8.
  function automatic logic [7:0] dec_ref(input logic [7:0] e, input logic [7:0] k);
    return rotl(~rev8(rotl(e, 3)), 5) ^ k;
  endfunction

  function automatic logic [7:0] enc(input logic [7:0] d, input logic [7:0] k);
    return rotl(rev8(~rotl(d ^ k, 3)), 5);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inspect the handshakes the coming edge will act on, then step past it.
  task automatic tick();
    @(negedge clock);
    if (in_valid && in_ready) accepted++;
    if (sb_en) begin
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(data), 32'(data_prev));
      end
      if (in_valid && in_ready) exp_q.push_back(cur_d);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
        else check("stream_data", 32'(data), 32'(exp_q.pop_front()));
      end
      stall_prev = out_valid && !out_ready;
      data_prev  = data;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [7:0] e,
                         input logic [7:0] k, input logic [7:0] exp, input bit chg);
    e_data = e; key = k; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    if (chg) begin
      key    = ~k;
      e_data = 8'($urandom);
    end
    for (int i = 1; i <= 4; i++) begin
      check({tag, "_early"}, 32'(out_valid), 32'd0);
      tick();
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(data), 32'(exp));
    tick();
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  task automatic drain(input string tag);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] d, k, rec;
    int  start, cyc;
    bit  seen;

    reset = 1'b1; key = '0; e_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef DECRYPTION_WORD_COUNT_EN
    check("rst_word_count", 32'(word_count), 32'd0);
`endif

    // First edge after release takes the word; five edges later it shows.
    reset = 1'b0;
    run_one("vec_66_5a", 8'h66, 8'h5A, 8'h3C, 1'b0);
    run_one("vec_zero", 8'h00, 8'h00, 8'hFF, 1'b0);
    run_one("key_change", 8'h66, 8'h5A, 8'h3C, 1'b1);
    d = 8'($urandom); k = 8'($urandom);
    run_one("rand_a", d, k, dec_ref(d, k), 1'b0);
    d = 8'($urandom); k = 8'($urandom);
    run_one("rand_b", d, k, dec_ref(d, k), 1'b1);

    // Fill the pipe, then stall the consumer for three cycles.
    sb_en = 1'b1; stall_prev = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cur_d = 8'($urandom); key = 8'($urandom);
      e_data = enc(cur_d, key); in_valid = 1'b1;
      tick();
    end
    cur_d = 8'($urandom); key = 8'($urandom);
    e_data = enc(cur_d, key); in_valid = 1'b1;
    check("bp_full", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    #1;
    check("bp_in_ready_drop", 32'(in_ready), 32'd0);
    rec = data;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(data), 32'(rec));
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    drain("bp");

    // Random stream with random gaps and random backpressure.
    start = accepted; cyc = 0;
    while (accepted - start < 1000 && cyc < 20000) begin
      in_valid = ($urandom_range(3) != 0);
      cur_d = 8'($urandom); key = 8'($urandom);
      e_data = enc(cur_d, key);
      out_ready = ($urandom_range(3) != 0);
      tick();
      cyc++;
    end
    check("stream_count", 32'(accepted - start), 32'd1000);
    drain("stream");
    sb_en = 1'b0;

    // Reset with words in flight, one of them already at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      key = 8'($urandom); e_data = 8'($urandom); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(data), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | out_valid;
    end
    check("post_rst_stale", 32'(seen), 32'd0);
    exp_q.delete();

`ifdef DECRYPTION_WORD_COUNT_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("wc_zero", 32'(word_count), 32'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      key = 8'($urandom); e_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("wc_wrap", 32'(word_count), 32'h0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
